branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Multi-cycle sequencer for control-flow instructions (B-type, JAL, JALR) in the RV32I multi-cycle core.
- Accepts a start handshake from the main control FSM, latches the operands and drives the registered branch comparator.
- Waits out the comparator's one-cycle latency, then returns next PC, redirect flag, link write-back and fault flags with a one-cycle done pulse.

Parameters:
- XLEN, 32, datapath width.
- IALIGN, 32, instruction alignment in bits: 32 checks target[1:0]; 16 checks target[0] only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only in IDLE
- flush  in  1  abort current operation
- opcode  in  7  instruction opcode
- func3  in  3  instruction func3
- pc  in  XLEN  PC of the instruction
- imm  in  XLEN  sign-extended immediate (B/J/I format, pre-decoded)
- rs1v  in  XLEN  rs1 value
- rs2v  in  XLEN  rs2 value
- bru_taken  in  1  comparator result (registered, 1-cycle latency)
- bru_opcode  out  7  opcode to comparator
- bru_func3  out  3  func3 to comparator
- bru_rs1v  out  XLEN  operand to comparator
- bru_rs2v  out  XLEN  operand to comparator
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle result-valid pulse
- redirect  out  1  PC must load next_pc
- next_pc  out  XLEN  resolved next PC
- rd_we  out  1  write pc+4 to rd (JAL/JALR only)
- rd_wdata  out  XLEN  link value
- misaligned  out  1  target-misaligned fault
- illegal  out  1  unsupported opcode or func3

Behaviour:
- Reset: go to IDLE. All outputs 0, including bru_opcode=0, which keeps the comparator result 0.
- States: IDLE, COMPARE, RESOLVE, DONE.
- IDLE, start=1, flush=0: latch opcode, func3, pc, imm, rs1v, rs2v.
  - B-type (1100011) -> COMPARE. bru_* outputs drive the latched values from the next cycle.
  - JAL (1101111) and JALR (1100111) -> RESOLVE directly.
  - Any other opcode -> RESOLVE with illegal pending.
- COMPARE: bru_* held stable; the comparator samples at the end of this cycle. -> RESOLVE.
- RESOLVE: compute the result; bru_opcode returns to 0. -> DONE.
- Target computation (all adds are XLEN-bit modulo, wrap-around allowed, no overflow flag):
  - B-type: target = pc + imm.
  - JAL: target = pc + imm.
  - JALR: target = (rs1v + imm) with bit 0 cleared.
- Misaligned: target[1:0]!=0 when IALIGN=32; target[0]!=0 when IALIGN=16.
- Illegal cases:
  - B-type with func3 010 or 011.
  - JALR with func3 != 000.
  - Unsupported opcode.
- Outputs in the DONE cycle, when illegal=1 (takes priority over misaligned):
  - redirect=0, rd_we=0, misaligned=0, next_pc=pc+4.
- Outputs in the DONE cycle, B-type (legal):
  - Taken (bru_taken sampled in RESOLVE) with aligned target: redirect=1, next_pc=target.
  - Taken with misaligned target: misaligned=1, redirect=0, next_pc=pc+4.
  - Not taken: redirect=0, next_pc=pc+4, misaligned=0. Misalignment is checked only when taken.
  - rd_we=0.
- Outputs in the DONE cycle, JAL/JALR (legal):
  - Aligned target: redirect=1, next_pc=target, rd_we=1, rd_wdata=pc+4.
  - Misaligned target: misaligned=1, redirect=0, rd_we=0.
- DONE state: done=1 for exactly one cycle, result outputs valid this cycle only, then -> IDLE.
  - Outside DONE: done, redirect, rd_we, misaligned and illegal are 0. next_pc and rd_wdata hold their last values.
- Latency from start to done: B-type 3 cycles; JAL/JALR/illegal 2 cycles.
- start while busy: ignored; latched operands do not change.
- flush in any non-IDLE state: -> IDLE next cycle, no done pulse, bru_opcode=0.
- flush and start together in IDLE: flush wins, request not accepted.
- flush in DONE: done still asserts that cycle (result already committed).
- rst mid-operation: immediate IDLE with reset values; rst has priority over flush and start.
- Input changes after acceptance have no effect.

Test Plan:
- BEQ: pc=0x100, imm=0x20, rs1v=rs2v=5 -> done 3 cycles after start, redirect=1, next_pc=0x120, rd_we=0.
- BLT not taken: rs1v=0x00000001, rs2v=0xFFFFFFFF, func3=100 -> redirect=0, next_pc=pc+4. Same operands with BLTU (110) -> taken.
- JALR: rs1v=0x203, imm=0, pc=0x40 -> done 2 cycles after start, next_pc=0x202, rd_we=1, rd_wdata=0x44. Repeat with IALIGN=32, rs1v=0x206 -> misaligned=1, redirect=0, rd_we=0.
- Illegal cases:
  - B-type func3=010 -> illegal=1, redirect=0.
  - Opcode 0110011 -> illegal=1, done after 2 cycles.
- Wrap: JAL pc=0xFFFFFFF0, imm=0x20 -> next_pc=0x00000010, rd_wdata=0xFFFFFFF4.
- Control cases:
  - flush asserted in COMPARE -> no done pulse, busy=0 next cycle.
  - start held high while busy -> exactly one done pulse.
  - rst asserted in RESOLVE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: request, result and comparator signals of the control-flow sequencer
//   master: main control FSM plus branch comparator (drives request and bru_taken)
//   slave : branch_ctrl (drives bru_* operands, busy/done and the resolved result)
interface branch_ctrl_if #(parameter int XLEN = 32);
    logic            start, flush;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [XLEN-1:0] pc, imm, rs1v, rs2v;
    logic            bru_taken;
    logic [6:0]      bru_opcode;
    logic [2:0]      bru_func3;
    logic [XLEN-1:0] bru_rs1v, bru_rs2v;
    logic            busy, done, redirect, rd_we, misaligned, illegal;
    logic [XLEN-1:0] next_pc, rd_wdata;
    modport master (
        output start, flush, opcode, func3, pc, imm, rs1v, rs2v, bru_taken,
        input  bru_opcode, bru_func3, bru_rs1v, bru_rs2v,
        input  busy, done, redirect, next_pc, rd_we, rd_wdata, misaligned, illegal
    );
    modport slave (
        input  start, flush, opcode, func3, pc, imm, rs1v, rs2v, bru_taken,
        output bru_opcode, bru_func3, bru_rs1v, bru_rs2v,
        output busy, done, redirect, next_pc, rd_we, rd_wdata, misaligned, illegal
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle B-type/JAL/JALR sequencer around a registered comparator
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of branch_ctrl_if (request in, bru_* out, result out)
module branch_ctrl #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input logic         clk,
    input logic         rst,
    branch_ctrl_if.slave bus
);
    localparam logic [6:0] OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    typedef enum logic [1:0] {IDLE, COMPARE, RESOLVE, DONE} state_t;
    state_t state, state_nxt;
    logic [6:0]      op_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q, npc_q, wdata_q, sum, target, link;
    logic            redir_q, we_q, mis_q, ill_q;
    logic            accept, is_b, is_jal, is_jalr, ill, mis, take;
    assign accept  = state == IDLE && bus.start && !bus.flush;
    assign is_b    = op_q == OP_B;
    assign is_jal  = op_q == OP_JAL;
    assign is_jalr = op_q == OP_JALR;
    assign ill     = is_b ? f3_q[2:1] == 2'b01 : is_jalr ? f3_q != 3'b000 : !is_jal;
    assign sum     = (is_jalr ? rs1_q : pc_q) + imm_q;
    assign target  = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign link    = pc_q + XLEN'(4);
    assign mis     = IALIGN == 16 ? target[0] : |target[1:0];
    // misalignment only matters for a branch that is actually taken
    assign take    = !is_b || bus.bru_taken;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (accept ? (bus.opcode == OP_B ? COMPARE : RESOLVE) : IDLE)
                  : (state == DONE || bus.flush) ? IDLE
                  : state == COMPARE ? RESOLVE : DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {op_q, f3_q, pc_q, imm_q, rs1_q, rs2_q} <= '0;
        end else if (accept) begin
            {op_q, f3_q, pc_q, imm_q, rs1_q, rs2_q} <= {bus.opcode, bus.func3, bus.pc, bus.imm, bus.rs1v, bus.rs2v};
        end
    end
    // results are resolved in RESOLVE and presented during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            {redir_q, we_q, mis_q, ill_q, npc_q, wdata_q} <= '0;
        end else if (state == RESOLVE && !bus.flush) begin
            redir_q <= !ill && take && !mis;
            we_q    <= !ill && !is_b && !mis;
            mis_q   <= !ill && take && mis;
            ill_q   <= ill;
            npc_q   <= (!ill && take && !mis) ? target : link;
            wdata_q <= link;
        end
    end
    always_comb begin
        bus.busy       = state != IDLE;
        bus.done       = state == DONE;
        bus.redirect   = state == DONE && redir_q;
        bus.rd_we      = state == DONE && we_q;
        bus.misaligned = state == DONE && mis_q;
        bus.illegal    = state == DONE && ill_q;
        bus.next_pc    = npc_q;
        bus.rd_wdata   = wdata_q;
        bus.bru_opcode = state == COMPARE ? op_q : 7'd0;
        bus.bru_func3  = f3_q;
        bus.bru_rs1v   = rs1_q;
        bus.bru_rs2v   = rs2_q;
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed bench for branch_ctrl with IALIGN=32 and IALIGN=16 instances
module tb_branch_ctrl;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    branch_ctrl_if #(.XLEN(32)) bus();
    branch_ctrl_if #(.XLEN(32)) bus16();
    branch_ctrl #(.XLEN(32), .IALIGN(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    branch_ctrl #(.XLEN(32), .IALIGN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    assign bus16.start     = bus.start;
    assign bus16.flush     = bus.flush;
    assign bus16.opcode    = bus.opcode;
    assign bus16.func3     = bus.func3;
    assign bus16.pc        = bus.pc;
    assign bus16.imm       = bus.imm;
    assign bus16.rs1v      = bus.rs1v;
    assign bus16.rs2v      = bus.rs2v;
    assign bus16.bru_taken = bus.bru_taken;
    function automatic logic bru_eval(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction
    always @(posedge clk) begin
        if (rst) bus.bru_taken <= 1'b0;
        else     bus.bru_taken <= bus.bru_opcode == 7'b1100011 && bru_eval(bus.bru_func3, bus.bru_rs1v, bus.bru_rs2v);
    end
    localparam logic [6:0] B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    int cmp_n = 0, err_n = 0;
    int lat;
    logic r_redir, r_we, r_mis, r_ill, r_done_after, s_redir, s_we, s_mis;
    logic [31:0] r_npc, r_wdata, s_npc, s_wdata;
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b);
        bus.opcode = op; bus.func3 = f3; bus.pc = p; bus.imm = im; bus.rs1v = a; bus.rs2v = b;
        bus.start = 1;
        lat = 0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            bus.start = 0;
            if (bus.done) begin
                lat = n;
                {r_redir, r_we, r_mis, r_ill, r_npc, r_wdata} = {bus.redirect, bus.rd_we, bus.misaligned, bus.illegal, bus.next_pc, bus.rd_wdata};
                {s_redir, s_we, s_mis, s_npc, s_wdata} = {bus16.redirect, bus16.rd_we, bus16.misaligned, bus16.next_pc, bus16.rd_wdata};
            end
        end
        @(posedge clk); #1;
        r_done_after = bus.done;
    endtask
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        cmp_n++; if ({bus.busy, bus.done, bus.redirect, bus.rd_we, bus.misaligned, bus.illegal} !== 6'b0) begin err_n++; $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.done, bus.redirect, bus.rd_we, bus.misaligned, bus.illegal}); end
        cmp_n++; if ({bus.next_pc, bus.rd_wdata} !== 64'h0) begin err_n++; $display("FAIL reset_data: got %h want 0", {bus.next_pc, bus.rd_wdata}); end
        cmp_n++; if ({bus.bru_opcode, bus.bru_func3, bus.bru_rs1v, bus.bru_rs2v} !== 74'h0) begin err_n++; $display("FAIL reset_bru: got %h want 0", {bus.bru_opcode, bus.bru_func3, bus.bru_rs1v, bus.bru_rs2v}); end
        rst = 0;
    endtask
    task automatic test_beq;
        run(B, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        cmp_n++; if (lat !== 3) begin err_n++; $display("FAIL beq_lat: got %0d want 3", lat); end
        cmp_n++; if ({r_redir, r_we, r_mis, r_ill} !== 4'b1000) begin err_n++; $display("FAIL beq_flags: got %b want 1000", {r_redir, r_we, r_mis, r_ill}); end
        cmp_n++; if (r_npc !== 32'h120) begin err_n++; $display("FAIL beq_npc: got %h want 00000120", r_npc); end
        cmp_n++; if (r_done_after !== 1'b0) begin err_n++; $display("FAIL beq_done_pulse: got %b want 0", r_done_after); end
    endtask
    task automatic test_blt;
        run(B, 3'b100, 32'h200, 32'h10, 32'h1, 32'hFFFFFFFF);
        cmp_n++; if ({r_redir, r_mis, r_ill} !== 3'b000) begin err_n++; $display("FAIL blt_flags: got %b want 000", {r_redir, r_mis, r_ill}); end
        cmp_n++; if (r_npc !== 32'h204) begin err_n++; $display("FAIL blt_npc: got %h want 00000204", r_npc); end
        run(B, 3'b110, 32'h200, 32'h10, 32'h1, 32'hFFFFFFFF);
        cmp_n++; if ({r_redir, r_we} !== 2'b10) begin err_n++; $display("FAIL bltu_flags: got %b want 10", {r_redir, r_we}); end
        cmp_n++; if (r_npc !== 32'h210) begin err_n++; $display("FAIL bltu_npc: got %h want 00000210", r_npc); end
    endtask
    task automatic test_branch_misaligned;
        run(B, 3'b001, 32'h100, 32'h22, 32'd1, 32'd2);
        cmp_n++; if ({r_redir, r_mis, r_ill} !== 3'b010) begin err_n++; $display("FAIL bmis_taken_flags: got %b want 010", {r_redir, r_mis, r_ill}); end
        cmp_n++; if (r_npc !== 32'h104) begin err_n++; $display("FAIL bmis_taken_npc: got %h want 00000104", r_npc); end
        run(B, 3'b001, 32'h100, 32'h22, 32'd3, 32'd3);
        cmp_n++; if ({r_redir, r_mis} !== 2'b00) begin err_n++; $display("FAIL bmis_nottaken_flags: got %b want 00", {r_redir, r_mis}); end
    endtask
    task automatic test_jalr;
        run(JALR, 3'b000, 32'h40, 32'h0, 32'h203, 32'h0);
        cmp_n++; if (lat !== 2) begin err_n++; $display("FAIL jalr_lat: got %0d want 2", lat); end
        cmp_n++; if ({s_redir, s_we, s_mis} !== 3'b110) begin err_n++; $display("FAIL jalr16_flags: got %b want 110", {s_redir, s_we, s_mis}); end
        cmp_n++; if ({s_npc, s_wdata} !== {32'h202, 32'h44}) begin err_n++; $display("FAIL jalr16_data: got %h want 0000020200000044", {s_npc, s_wdata}); end
        run(JALR, 3'b000, 32'h40, 32'h0, 32'h206, 32'h0);
        cmp_n++; if ({r_redir, r_we, r_mis, r_ill} !== 4'b0010) begin err_n++; $display("FAIL jalr32_mis_flags: got %b want 0010", {r_redir, r_we, r_mis, r_ill}); end
        run(JALR, 3'b000, 32'h80, 32'h3, 32'h205, 32'h0);
        cmp_n++; if ({r_redir, r_we, r_npc, r_wdata} !== {2'b11, 32'h208, 32'h84}) begin err_n++; $display("FAIL jalr32_ok: got %h want 30000020800000084", {r_redir, r_we, r_npc, r_wdata}); end
    endtask
    task automatic test_illegal;
        run(B, 3'b010, 32'h300, 32'h8, 32'd5, 32'd5);
        cmp_n++; if ({r_redir, r_we, r_mis, r_ill} !== 4'b0001) begin err_n++; $display("FAIL ill_b_flags: got %b want 0001", {r_redir, r_we, r_mis, r_ill}); end
        cmp_n++; if (r_npc !== 32'h304) begin err_n++; $display("FAIL ill_b_npc: got %h want 00000304", r_npc); end
        run(7'b0110011, 3'b000, 32'h400, 32'h8, 32'd1, 32'd1);
        cmp_n++; if (lat !== 2) begin err_n++; $display("FAIL ill_op_lat: got %0d want 2", lat); end
        cmp_n++; if ({r_redir, r_we, r_mis, r_ill} !== 4'b0001) begin err_n++; $display("FAIL ill_op_flags: got %b want 0001", {r_redir, r_we, r_mis, r_ill}); end
        run(JALR, 3'b001, 32'h500, 32'h0, 32'h600, 32'h0);
        cmp_n++; if ({r_redir, r_we, r_ill, r_npc} !== {3'b001, 32'h504}) begin err_n++; $display("FAIL ill_jalr: got %h want 100000504", {r_redir, r_we, r_ill, r_npc}); end
    endtask
    task automatic test_wrap;
        run(JAL, 3'b000, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0);
        cmp_n++; if (lat !== 2) begin err_n++; $display("FAIL wrap_lat: got %0d want 2", lat); end
        cmp_n++; if ({r_redir, r_we, r_npc, r_wdata} !== {2'b11, 32'h10, 32'hFFFFFFF4}) begin err_n++; $display("FAIL wrap_data: got %h want 300000010FFFFFFF4", {r_redir, r_we, r_npc, r_wdata}); end
    endtask
    task automatic test_flush;
        int pulses = 0;
        bus.opcode = B; bus.func3 = 3'b000; bus.pc = 32'h700; bus.imm = 32'h20; bus.rs1v = 1; bus.rs2v = 1;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0;
        cmp_n++; if ({bus.busy, bus.bru_opcode} !== 8'h0) begin err_n++; $display("FAIL flush_compare: got %h want 00", {bus.busy, bus.bru_opcode}); end
        for (int n = 0; n < 5; n++) begin @(posedge clk); #1; if (bus.done) pulses++; end
        cmp_n++; if (pulses !== 0) begin err_n++; $display("FAIL flush_no_done: got %0d want 0", pulses); end
        bus.start = 1; bus.flush = 1;
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 0;
        cmp_n++; if (bus.busy !== 1'b0) begin err_n++; $display("FAIL flush_start_idle: got %b want 0", bus.busy); end
        bus.opcode = JAL; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        bus.flush = 1;
        cmp_n++; if (bus.done !== 1'b1) begin err_n++; $display("FAIL flush_in_done: got %b want 1", bus.done); end
        @(posedge clk); #1;
        bus.flush = 0;
        cmp_n++; if ({bus.busy, bus.done} !== 2'b00) begin err_n++; $display("FAIL flush_after_done: got %b want 00", {bus.busy, bus.done}); end
    endtask
    task automatic test_back_to_back;
        int pulses = 0;
        logic [31:0] seen = 0;
        bus.opcode = B; bus.func3 = 3'b000; bus.pc = 32'h100; bus.imm = 32'h20; bus.rs1v = 5; bus.rs2v = 5;
        bus.start = 1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin bus.pc = 32'h500; bus.imm = 32'h40; bus.rs2v = 7; end
            if (bus.done) begin pulses++; seen = bus.next_pc; bus.start = 0; end
        end
        bus.start = 0;
        cmp_n++; if (pulses !== 1) begin err_n++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
        cmp_n++; if (seen !== 32'h120) begin err_n++; $display("FAIL b2b_latched: got %h want 00000120", seen); end
    endtask
    task automatic test_rst_mid;
        bus.opcode = B; bus.func3 = 3'b000; bus.pc = 32'h100; bus.imm = 32'h20; bus.rs1v = 9; bus.rs2v = 9;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        cmp_n++; if ({bus.busy, bus.done, bus.redirect, bus.rd_we, bus.misaligned, bus.illegal} !== 6'b0) begin err_n++; $display("FAIL rst_mid_flags: got %b want 000000", {bus.busy, bus.done, bus.redirect, bus.rd_we, bus.misaligned, bus.illegal}); end
        cmp_n++; if ({bus.next_pc, bus.rd_wdata, bus.bru_rs1v} !== 96'h0) begin err_n++; $display("FAIL rst_mid_data: got %h want 0", {bus.next_pc, bus.rd_wdata, bus.bru_rs1v}); end
        rst = 0;
    endtask
    initial begin
        bus.start = 0; bus.flush = 0; bus.opcode = 0; bus.func3 = 0;
        bus.pc = 0; bus.imm = 0; bus.rs1v = 0; bus.rs2v = 0;
        test_reset;
        test_beq;
        test_blt;
        test_branch_misaligned;
        test_jalr;
        test_illegal;
        test_wrap;
        test_flush;
        test_back_to_back;
        test_rst_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
